// File: rtl/dds_voice_engine_pkg.sv
// Shared definitions for the time-multiplexed DDS voice engine:
// slot encodings, the slot count per voice and default widths.
package dds_voice_engine_pkg;

    localparam int unsigned SLOTS_PER_VOICE = 4;

    localparam int unsigned DEF_NUM_VOICES = 8;
    localparam int unsigned DEF_VIDX_W     = 8;
    localparam int unsigned DEF_PHASE_W    = 32;
    localparam int unsigned DEF_OUT_W      = 10;

    typedef enum logic [$clog2(SLOTS_PER_VOICE)-1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } slot_e;

endpackage

// File: rtl/dds_voice_engine_if.sv
// Tuning-command handshake, phase stream and monitor tap of the DDS voice engine.
interface dds_voice_engine_if #(
    parameter int unsigned VIDX_W  = 8,
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned OUT_W   = 10
);
    logic               i_tune_valid;
    logic               o_tune_ready;
    logic [VIDX_W-1:0]  i_tune_voice;
    logic [PHASE_W-1:0] i_tune_word;
    logic               i_tune_clr;
    logic [VIDX_W-1:0]  i_mon_voice;
    logic               o_valid;
    logic [VIDX_W-1:0]  o_voice;
    logic [OUT_W-1:0]   o_phase;
    logic               o_frame;
    logic [OUT_W-1:0]   o_mon_phase;

    modport master (
        output i_tune_valid, i_tune_voice, i_tune_word, i_tune_clr, i_mon_voice,
        input  o_tune_ready, o_valid, o_voice, o_phase, o_frame, o_mon_phase
    );

    modport slave (
        input  i_tune_valid, i_tune_voice, i_tune_word, i_tune_clr, i_mon_voice,
        output o_tune_ready, o_valid, o_voice, o_phase, o_frame, o_mon_phase
    );
endinterface

// File: rtl/dds_voice_engine_ram.sv
// Per-voice accumulator and tuning-word storage: one read port, an accumulator
// writeback port and a command port whose slots never overlap.
module dds_voice_ram
    import dds_voice_engine_pkg::*;
#(
    parameter int unsigned NUM_VOICES = DEF_NUM_VOICES,
    parameter int unsigned PHASE_W    = DEF_PHASE_W,
    parameter int unsigned AW         = $clog2(NUM_VOICES)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [AW-1:0]      rd_addr,
    output logic [PHASE_W-1:0] rd_acc,
    output logic [PHASE_W-1:0] rd_tune,
    input  logic               wb_en,
    input  logic [AW-1:0]      wb_addr,
    input  logic [PHASE_W-1:0] wb_data,
    input  logic               cmd_en,
    input  logic [AW-1:0]      cmd_addr,
    input  logic [PHASE_W-1:0] cmd_word,
    input  logic               cmd_clr
);
    logic [PHASE_W-1:0] acc  [NUM_VOICES];
    logic [PHASE_W-1:0] tune [NUM_VOICES];

    assign rd_acc  = acc[rd_addr];
    assign rd_tune = tune[rd_addr];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                acc[AW'(i)]  <= '0;
                tune[AW'(i)] <= '0;
            end
        end else begin
            if (wb_en)
                acc[wb_addr] <= wb_data;
            if (cmd_en) begin
                tune[cmd_addr] <= cmd_word;
                if (cmd_clr)
                    acc[cmd_addr] <= '0;
            end
        end
    end

endmodule

// File: rtl/dds_voice_engine.sv
// Time-multiplexed DDS phase engine: one shared adder steps NUM_VOICES phase
// accumulators, one voice per four-slot group, with a one-deep tuning buffer.
module dds_voice_engine
    import dds_voice_engine_pkg::*;
#(
    parameter int unsigned NUM_VOICES = DEF_NUM_VOICES,
    parameter int unsigned VIDX_W     = DEF_VIDX_W,
    parameter int unsigned PHASE_W    = DEF_PHASE_W,
    parameter int unsigned OUT_W      = DEF_OUT_W
) (
    input  logic i_clk,
    input  logic i_reset_n,
    dds_voice_engine_if.slave bus
);
    localparam int unsigned       AW         = $clog2(NUM_VOICES);
    localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(NUM_VOICES - 1);
    localparam logic [VIDX_W:0]   NV_EXT     = (VIDX_W + 1)'(NUM_VOICES);

    slot_e              state, state_nxt;
    logic               rd_en, add_en, wb_en, cmd_slot;
    logic [VIDX_W-1:0]  voice;
    logic [PHASE_W-1:0] rd_acc, rd_tune, acc_r, tune_r, sum_r;

    logic               pend, pend_clr, accept, cmd_en;
    logic [VIDX_W-1:0]  pend_voice;
    logic [PHASE_W-1:0] pend_word;

    logic               valid_q, frame_q;
    logic [VIDX_W-1:0]  voice_q;
    logic [OUT_W-1:0]   phase_q, mon_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= S0;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = S0;
        unique case (state)
            S0: state_nxt = S1;
            S1: state_nxt = S2;
            S2: state_nxt = S3;
            S3: state_nxt = S0;
            default: state_nxt = S0;
        endcase
    end

    always_comb begin
        rd_en    = (state == S0);
        add_en   = (state == S1);
        wb_en    = (state == S2);
        cmd_slot = (state == S3);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            voice <= '0;
        else if (cmd_slot)
            voice <= (voice == LAST_VOICE) ? '0 : voice + VIDX_W'(1);
    end

    dds_voice_ram #(
        .NUM_VOICES (NUM_VOICES),
        .PHASE_W    (PHASE_W),
        .AW         (AW)
    ) u_ram (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .rd_addr   (voice[AW-1:0]),
        .rd_acc    (rd_acc),
        .rd_tune   (rd_tune),
        .wb_en     (wb_en),
        .wb_addr   (voice[AW-1:0]),
        .wb_data   (sum_r),
        .cmd_en    (cmd_en),
        .cmd_addr  (pend_voice[AW-1:0]),
        .cmd_word  (pend_word),
        .cmd_clr   (pend_clr)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_r  <= '0;
            tune_r <= '0;
            sum_r  <= '0;
        end else begin
            if (rd_en) begin
                acc_r  <= rd_acc;
                tune_r <= rd_tune;
            end
            if (add_en)
                sum_r <= acc_r + tune_r;
        end
    end

    // Commands land in S3, after S2 writeback, so they never race an update.
    assign accept = bus.i_tune_valid & ~pend;
    assign cmd_en = cmd_slot & pend & ({1'b0, pend_voice} < NV_EXT);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pend       <= 1'b0;
            pend_voice <= '0;
            pend_word  <= '0;
            pend_clr   <= 1'b0;
        end else if (accept) begin
            pend       <= 1'b1;
            pend_voice <= bus.i_tune_voice;
            pend_word  <= bus.i_tune_word;
            pend_clr   <= bus.i_tune_clr;
        end else if (cmd_slot) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            voice_q <= '0;
            phase_q <= '0;
            mon_q   <= '0;
        end else begin
            valid_q <= wb_en;
            frame_q <= wb_en && (voice == LAST_VOICE);
            if (wb_en) begin
                voice_q <= voice;
                phase_q <= sum_r[PHASE_W-1 -: OUT_W];
            end
            if (valid_q && (voice_q == bus.i_mon_voice))
                mon_q <= phase_q;
        end
    end

    assign bus.o_tune_ready = ~pend;
    assign bus.o_valid      = valid_q;
    assign bus.o_frame      = frame_q;
    assign bus.o_voice      = voice_q;
    assign bus.o_phase      = phase_q;
    assign bus.o_mon_phase  = mon_q;

endmodule

// File: tb/tb_dds_voice_engine.sv
// Self-checking bench for dds_voice_engine against a per-voice arithmetic model.
module tb_dds_voice_engine;

    localparam int unsigned NV = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dds_voice_engine_if #(.VIDX_W(8), .PHASE_W(32), .OUT_W(10)) bus();

    dds_voice_engine #(
        .NUM_VOICES (8),
        .VIDX_W     (8),
        .PHASE_W    (32),
        .OUT_W      (10)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: voice v is advanced by its tuning word in slot group v of
    // each frame; commands queue one deep and take effect at the group's last clock.
    int unsigned k;
    logic [31:0] acc_m [NV];
    logic [31:0] tune_m [NV];
    bit          pend_m, pc, acc_now;
    int unsigned pv;
    logic [31:0] pw;
    logic        exp_valid, exp_frame;
    logic [7:0]  exp_voice;
    logic [9:0]  exp_phase, exp_mon;

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < int'(NV); i++) begin
            acc_m[i]  = '0;
            tune_m[i] = '0;
        end
        pend_m = 0; acc_now = 0;
        exp_valid = 0; exp_frame = 0; exp_voice = '0; exp_phase = '0; exp_mon = '0;
    endtask

    task automatic step();
        bit          take;
        int unsigned ph, v, tv, mv;
        logic [31:0] s, tw;
        bit          tc;
        take = bus.i_tune_valid && !pend_m;
        tv = bus.i_tune_voice; tw = bus.i_tune_word; tc = bus.i_tune_clr;
        mv = bus.i_mon_voice;
        @(posedge clk);
        k++;
        ph = (k - 1) % 4;
        v  = ((k - 1) / 4) % NV;
        if (exp_valid && exp_voice == 8'(mv)) exp_mon = exp_phase;
        exp_valid = (ph == 2);
        exp_frame = (ph == 2) && (v == NV - 1);
        if (ph == 2) begin
            s = acc_m[v] + tune_m[v];
            acc_m[v] = s;
            exp_phase = s[31:22];
            exp_voice = 8'(v);
        end
        if (ph == 3 && pend_m) begin
            if (pv < NV) begin
                tune_m[pv] = pw;
                if (pc) acc_m[pv] = '0;
            end
            pend_m = 0;
        end
        acc_now = take;
        if (take) begin
            pend_m = 1; pv = tv; pw = tw; pc = tc;
        end
        #1;
    endtask

    task automatic send_cmd(input int unsigned v, input logic [31:0] w, input bit c,
                            output int waits);
        bus.i_tune_valid = 1'b1;
        bus.i_tune_voice = 8'(v);
        bus.i_tune_word  = w;
        bus.i_tune_clr   = c;
        waits = 0;
        do begin
            n_tests++;
            if (bus.o_tune_ready !== (pend_m ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL ready k=%0d: got %b exp %b", k, bus.o_tune_ready, !pend_m);
            end
            step();
            if (!acc_now) waits++;
        end while (!acc_now && waits < 20);
        n_tests++;
        if (!acc_now) begin
            n_fail++;
            $display("FAIL accept_timeout: got no accept after %0d cycles, exp accept", waits);
        end
    endtask

    task automatic test_reset();
        bus.i_tune_valid = 1'b0; bus.i_tune_voice = '0; bus.i_tune_word = '0;
        bus.i_tune_clr = 1'b0; bus.i_mon_voice = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests += 6;
        if (bus.o_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_valid: got %b exp 0", bus.o_valid); end
        if (bus.o_voice !== 8'd0)     begin n_fail++; $display("FAIL rst_voice: got %0d exp 0", bus.o_voice); end
        if (bus.o_phase !== 10'd0)    begin n_fail++; $display("FAIL rst_phase: got %0d exp 0", bus.o_phase); end
        if (bus.o_frame !== 1'b0)     begin n_fail++; $display("FAIL rst_frame: got %b exp 0", bus.o_frame); end
        if (bus.o_mon_phase !== 10'd0) begin n_fail++; $display("FAIL rst_mon: got %0d exp 0", bus.o_mon_phase); end
        if (bus.o_tune_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", bus.o_tune_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 72; i++) begin
            step();
            n_tests += 4;
            if (bus.o_valid !== exp_valid) begin n_fail++; $display("FAIL rel_valid k=%0d: got %b exp %b", k, bus.o_valid, exp_valid); end
            if (bus.o_voice !== exp_voice) begin n_fail++; $display("FAIL rel_voice k=%0d: got %0d exp %0d", k, bus.o_voice, exp_voice); end
            if (bus.o_phase !== exp_phase) begin n_fail++; $display("FAIL rel_phase k=%0d: got %0d exp %0d", k, bus.o_phase, exp_phase); end
            if (bus.o_frame !== exp_frame) begin n_fail++; $display("FAIL rel_frame k=%0d: got %b exp %b", k, bus.o_frame, exp_frame); end
        end
    endtask

    task automatic test_phase_step();
        int w;
        bus.i_mon_voice = 8'd5;
        send_cmd(5, 32'h0040_0000, 1'b0, w);
        bus.i_tune_valid = 1'b0;
        for (int i = 0; i < 128; i++) begin
            step();
            n_tests += 3;
            if (bus.o_valid !== exp_valid) begin n_fail++; $display("FAIL step_valid k=%0d: got %b exp %b", k, bus.o_valid, exp_valid); end
            if (bus.o_phase !== exp_phase) begin n_fail++; $display("FAIL step_phase k=%0d: got %0d exp %0d", k, bus.o_phase, exp_phase); end
            if (bus.o_mon_phase !== exp_mon) begin n_fail++; $display("FAIL step_mon k=%0d: got %0d exp %0d", k, bus.o_mon_phase, exp_mon); end
        end
    endtask

    task automatic test_wrap();
        int w;
        send_cmd(2, 32'h8000_0000, 1'b1, w);
        bus.i_tune_valid = 1'b0;
        for (int i = 0; i < 128; i++) begin
            step();
            n_tests += 2;
            if (bus.o_voice !== exp_voice) begin n_fail++; $display("FAIL wrap_voice k=%0d: got %0d exp %0d", k, bus.o_voice, exp_voice); end
            if (bus.o_phase !== exp_phase) begin n_fail++; $display("FAIL wrap_phase k=%0d: got %0d exp %0d", k, bus.o_phase, exp_phase); end
        end
    endtask

    task automatic test_back_to_back();
        int w1, w2;
        bus.i_mon_voice = 8'd1;
        send_cmd(1, 32'h0000_0100, 1'b0, w1);
        send_cmd(1, 32'h0000_0200, 1'b1, w2);
        bus.i_tune_valid = 1'b0;
        n_tests += 2;
        if (w2 > 5) begin n_fail++; $display("FAIL b2b_latency: got %0d wait cycles exp <= 5", w2); end
        if (bus.o_tune_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low: got %b exp 0", bus.o_tune_ready); end
        for (int i = 0; i < 72; i++) begin
            step();
            n_tests += 3;
            if (bus.o_tune_ready !== (pend_m ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL b2b_ready k=%0d: got %b exp %b", k, bus.o_tune_ready, !pend_m); end
            if (bus.o_phase !== exp_phase) begin n_fail++; $display("FAIL b2b_phase k=%0d: got %0d exp %0d", k, bus.o_phase, exp_phase); end
            if (bus.o_mon_phase !== exp_mon) begin n_fail++; $display("FAIL b2b_mon k=%0d: got %0d exp %0d", k, bus.o_mon_phase, exp_mon); end
        end
    endtask

    task automatic test_out_of_range();
        int w;
        send_cmd(9, 32'hFFFF_FFFF, 1'b1, w);
        bus.i_tune_valid = 1'b0;
        n_tests++;
        if (bus.o_tune_ready !== 1'b0) begin n_fail++; $display("FAIL oor_ready_low: got %b exp 0", bus.o_tune_ready); end
        for (int i = 0; i < 72; i++) begin
            step();
            n_tests += 3;
            if (bus.o_tune_ready !== (pend_m ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL oor_ready k=%0d: got %b exp %b", k, bus.o_tune_ready, !pend_m); end
            if (bus.o_voice !== exp_voice) begin n_fail++; $display("FAIL oor_voice k=%0d: got %0d exp %0d", k, bus.o_voice, exp_voice); end
            if (bus.o_phase !== exp_phase) begin n_fail++; $display("FAIL oor_phase k=%0d: got %0d exp %0d", k, bus.o_phase, exp_phase); end
        end
    endtask

    task automatic test_random();
        int w;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) bus.i_mon_voice = 8'($urandom_range(0, NV - 1));
            send_cmd($urandom_range(0, 9), $urandom, ($urandom_range(0, 3) == 0), w);
            bus.i_tune_valid = 1'b0;
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
                step();
                n_tests += 6;
                if (bus.o_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid k=%0d: got %b exp %b", k, bus.o_valid, exp_valid); end
                if (bus.o_voice !== exp_voice) begin n_fail++; $display("FAIL rnd_voice k=%0d: got %0d exp %0d", k, bus.o_voice, exp_voice); end
                if (bus.o_phase !== exp_phase) begin n_fail++; $display("FAIL rnd_phase k=%0d: got %0d exp %0d", k, bus.o_phase, exp_phase); end
                if (bus.o_frame !== exp_frame) begin n_fail++; $display("FAIL rnd_frame k=%0d: got %b exp %b", k, bus.o_frame, exp_frame); end
                if (bus.o_mon_phase !== exp_mon) begin n_fail++; $display("FAIL rnd_mon k=%0d: got %0d exp %0d", k, bus.o_mon_phase, exp_mon); end
                if (bus.o_tune_ready !== (pend_m ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL rnd_ready k=%0d: got %b exp %b", k, bus.o_tune_ready, !pend_m); end
            end
        end
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        // stop just before the S0 edge of voice 3, then post a command on that edge
        while (!((k / 4) % NV == 3 && k % 4 == 0) && guard < 64) begin
            step();
            guard++;
        end
        n_tests++;
        if (guard >= 64) begin n_fail++; $display("FAIL mid_align: got no voice-3 slot in %0d cycles", guard); end
        bus.i_tune_valid = 1'b1; bus.i_tune_voice = 8'd4;
        bus.i_tune_word = 32'h1234_5678; bus.i_tune_clr = 1'b0;
        step();
        bus.i_tune_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests += 6;
        if (bus.o_valid !== 1'b0)      begin n_fail++; $display("FAIL mid_valid: got %b exp 0", bus.o_valid); end
        if (bus.o_voice !== 8'd0)      begin n_fail++; $display("FAIL mid_voice: got %0d exp 0", bus.o_voice); end
        if (bus.o_phase !== 10'd0)     begin n_fail++; $display("FAIL mid_phase: got %0d exp 0", bus.o_phase); end
        if (bus.o_frame !== 1'b0)      begin n_fail++; $display("FAIL mid_frame: got %b exp 0", bus.o_frame); end
        if (bus.o_mon_phase !== 10'd0) begin n_fail++; $display("FAIL mid_mon: got %0d exp 0", bus.o_mon_phase); end
        if (bus.o_tune_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b exp 1", bus.o_tune_ready); end
        model_reset();
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            n_tests += 4;
            if (bus.o_valid !== exp_valid) begin n_fail++; $display("FAIL mid_rel_valid k=%0d: got %b exp %b", k, bus.o_valid, exp_valid); end
            if (bus.o_voice !== exp_voice) begin n_fail++; $display("FAIL mid_rel_voice k=%0d: got %0d exp %0d", k, bus.o_voice, exp_voice); end
            if (bus.o_phase !== exp_phase) begin n_fail++; $display("FAIL mid_rel_phase k=%0d: got %0d exp %0d", k, bus.o_phase, exp_phase); end
            if (bus.o_tune_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_ready k=%0d: got %b exp 1", k, bus.o_tune_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_phase_step();
        test_wrap();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
